// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect-4 turn sequencer.
package c4_pkg;

  localparam int C4_COLS = 7;
  localparam int C4_ROWS = 6;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    DROP  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } tc_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  function automatic player_t other_player(input player_t p);
    return (p == P1) ? P2 : P1;
  endfunction

  function automatic logic [1:0] win_code(input player_t p);
    return (p == P1) ? WIN_P1 : WIN_P2;
  endfunction

endpackage

// File: rtl/col_heights.sv
// Per-column fill heights for the board. A column is full once its height
// reaches ROWS; a column index outside the board also reads as full so the
// sequencer can treat both cases as one illegal-move condition.
module col_heights
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic [2:0] inc_col,
  input  logic [2:0] rd_col,
  output logic [2:0] rd_height,
  output logic       full
);

  logic [2:0] height_q [COLS];
  logic [2:0] height_d [COLS];

  // Next heights: a clear wins, otherwise bump the chosen column, saturating at ROWS
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      height_d[i] = height_q[i];
      if (clear) begin
        height_d[i] = '0;
      end else if (inc && (32'(inc_col) == i) && (height_q[i] != 3'(ROWS))) begin
        height_d[i] = height_q[i] + 3'd1;
      end
    end
  end

  // Height register array
  always_ff @(posedge clk) begin
    for (int i = 0; i < COLS; i++) begin
      if (reset) begin
        height_q[i] <= '0;
      end else begin
        height_q[i] <= height_d[i];
      end
    end
  end

  // Read port: out-of-range columns report a full height
  always_comb begin
    rd_height = 3'(ROWS);
    for (int i = 0; i < COLS; i++) begin
      if (32'(rd_col) == i) begin
        rd_height = height_q[i];
      end
    end
  end

  assign full = (rd_height == 3'(ROWS));

endmodule

// File: rtl/turn_ctrl.sv
// Connect-4 game sequencer: owns the turn, validates confirmed moves,
// issues the board write and handshakes with the external win checker.
// Optional build macro TURN_TIMER_EN adds a per-turn idle timer that
// forfeits the turn after TURN_TIMEOUT cycles in WAIT.
module turn_ctrl
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS,
  parameter int TURN_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       confirm_pulse,
  input  logic [2:0] col,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic       player,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic       wr_player,
  output logic       chk_start,
  output logic       clear_board,
  output logic       reject_pulse,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       timeout_pulse
);

  localparam logic [5:0] BOARD_CELLS = 6'(ROWS * COLS);

  tc_state_t  state_q, state_d;
  player_t    player_q, player_d;
  player_t    wr_player_q, wr_player_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [5:0] move_cnt_q, move_cnt_d;
  logic [1:0] winner_q, winner_d;
  logic       reject_q, reject_d;
  logic       chk_start_q, chk_start_d;
  logic       clear_q, clear_d;

  logic       heights_inc;
  logic       heights_clr;
  logic [2:0] rd_height;
  logic       col_full;
  logic       timer_expired;

  col_heights #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_heights (
    .clk      (clk),
    .reset    (reset),
    .clear    (heights_clr),
    .inc      (heights_inc),
    .inc_col  (col_q),
    .rd_col   (col),
    .rd_height(rd_height),
    .full     (col_full)
  );

`ifdef TURN_TIMER_EN
  localparam int TW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
  logic [TW-1:0] timer_q;

  // Idle counter: only runs in WAIT, restarts on entry, expiry or a new game
  always_ff @(posedge clk) begin
    if (reset || new_game || (state_q != WAIT) || timer_expired) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timer_expired = (state_q == WAIT) && (timer_q == TW'(TURN_TIMEOUT - 1));
`else
  assign timer_expired = 1'b0;
`endif

  // Next-state and pulse decode; new_game overrides every transition
  always_comb begin
    state_d       = state_q;
    player_d      = player_q;
    wr_player_d   = wr_player_q;
    col_d         = col_q;
    row_d         = row_q;
    move_cnt_d    = move_cnt_q;
    winner_d      = winner_q;
    reject_d      = 1'b0;
    chk_start_d   = 1'b0;
    clear_d       = 1'b0;
    heights_inc   = 1'b0;
    heights_clr   = 1'b0;
    timeout_pulse = 1'b0;

    if (new_game) begin
      state_d     = WAIT;
      player_d    = P1;
      wr_player_d = P1;
      col_d       = '0;
      row_d       = '0;
      move_cnt_d  = '0;
      winner_d    = WIN_NONE;
      clear_d     = 1'b1;
      heights_clr = 1'b1;
    end else begin
      case (state_q)
        WAIT: begin
          if (confirm_pulse) begin
            if (col_full) begin
              reject_d = 1'b1;
            end else begin
              col_d       = col;
              row_d       = rd_height;
              wr_player_d = player_q;
              state_d     = DROP;
            end
          end else if (timer_expired) begin
            timeout_pulse = 1'b1;
            player_d      = other_player(player_q);
          end
        end
        DROP: begin
          heights_inc = 1'b1;
          move_cnt_d  = move_cnt_q + 6'd1;
          chk_start_d = 1'b1;
          state_d     = CHECK;
        end
        CHECK: begin
          if (chk_done) begin
            if (chk_win) begin
              winner_d = win_code(player_q);
              state_d  = OVER;
            end else if (move_cnt_q == BOARD_CELLS) begin
              winner_d = WIN_DRAW;
              state_d  = OVER;
            end else begin
              player_d = other_player(player_q);
              state_d  = WAIT;
            end
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = WAIT;
        end
      endcase
    end
  end

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT;
      player_q    <= P1;
      wr_player_q <= P1;
      col_q       <= '0;
      row_q       <= '0;
      move_cnt_q  <= '0;
      winner_q    <= WIN_NONE;
      reject_q    <= 1'b0;
      chk_start_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      wr_player_q <= wr_player_d;
      col_q       <= col_d;
      row_q       <= row_d;
      move_cnt_q  <= move_cnt_d;
      winner_q    <= winner_d;
      reject_q    <= reject_d;
      chk_start_q <= chk_start_d;
      clear_q     <= clear_d;
    end
  end

  // A new_game arriving during DROP abandons the move, so the strobe is gated
  assign wr_en        = (state_q == DROP) && !new_game;
  assign wr_row       = row_q;
  assign wr_col       = col_q;
  assign wr_player    = wr_player_q;
  assign player       = player_q;
  assign chk_start    = chk_start_q;
  assign clear_board  = clear_q;
  assign reject_pulse = reject_q;
  assign game_over    = (state_q == OVER);
  assign winner       = winner_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Self-checking bench for turn_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized games against a move-level model.
`timescale 1ns/1ps
module tb_turn_ctrl;

`ifdef TURN_TIMER_EN
  localparam int TbTimeout = 10;
`else
  localparam int TbTimeout = 500_000_000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       newGamePulse;
  logic       confirmPulse;
  logic [2:0] colSel;
  logic       chkDone;
  logic       chkWin;
  logic       playerOut;
  logic       wrEn;
  logic [2:0] wrRow;
  logic [2:0] wrCol;
  logic       wrPlayer;
  logic       chkStart;
  logic       clearBoard;
  logic       rejectPulse;
  logic       gameOver;
  logic [1:0] winnerOut;
  logic       timeoutPulse;

  int compares = 0;
  int failures = 0;
  logic sawTimeout = 1'b0;

  // Move-level reference model
  int mHeight[7];
  int mMoves;
  int mTurn;
  int mOver;
  int mWinner;

  typedef struct {
    logic [2:0] c;
    logic       win;
    logic       expWr;
    logic       expRej;
    logic [2:0] expRow;
    logic       expWrp;
    logic       expPlayer;
    logic       expOver;
    logic [1:0] expWinner;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  turn_ctrl #(.TURN_TIMEOUT(TbTimeout)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (newGamePulse),
    .confirm_pulse(confirmPulse),
    .col          (colSel),
    .chk_done     (chkDone),
    .chk_win      (chkWin),
    .player       (playerOut),
    .wr_en        (wrEn),
    .wr_row       (wrRow),
    .wr_col       (wrCol),
    .wr_player    (wrPlayer),
    .chk_start    (chkStart),
    .clear_board  (clearBoard),
    .reject_pulse (rejectPulse),
    .game_over    (gameOver),
    .winner       (winnerOut),
    .timeout_pulse(timeoutPulse)
  );

  always @(negedge clk) if (timeoutPulse) sawTimeout = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 7; i++) mHeight[i] = 0;
    mMoves = 0; mTurn = 0; mOver = 0; mWinner = 0;
  endtask

  task automatic startNewGame();
    @(negedge clk); newGamePulse = 1'b1;
    @(negedge clk); newGamePulse = 1'b0;
    checkOutput("newgame_clear_board", 32'(clearBoard), 1);
    checkOutput("newgame_player", 32'(playerOut), 0);
    checkOutput("newgame_game_over", 32'(gameOver), 0);
    checkOutput("newgame_winner", 32'(winnerOut), 0);
    modelReset();
  endtask

  // One confirm; when a write follows, also performs the win-check handshake
  task automatic runMove(input logic [2:0] c, input logic win,
                         output logic gotWr, output logic gotRej, output logic gotChk,
                         output logic gotStray, output logic [2:0] gotRow,
                         output logic [2:0] gotCol, output logic gotWrp);
    int dly;
    @(negedge clk); confirmPulse = 1'b1; colSel = c;
    @(negedge clk); confirmPulse = 1'b0;
    gotWr = wrEn; gotRej = rejectPulse; gotRow = wrRow; gotCol = wrCol; gotWrp = wrPlayer;
    gotChk = 1'b0; gotStray = 1'b0;
    if (gotWr) begin
      @(negedge clk);
      gotChk = chkStart;
      gotStray = wrEn;
      dly = $urandom_range(0, 2);
      for (int i = 0; i < dly; i++) begin
        confirmPulse = 1'($urandom_range(0, 1));
        colSel = 3'($urandom_range(0, 6));
        @(negedge clk);
        gotStray = gotStray | rejectPulse | wrEn | chkStart;
      end
      confirmPulse = 1'b0;
      chkDone = 1'b1; chkWin = win;
      @(negedge clk);
      chkDone = 1'b0; chkWin = 1'b0;
      gotStray = gotStray | rejectPulse | wrEn;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic gw, gr, gc, gs, gp;
    logic [2:0] grow, gcol;
    string tag;
    tag = $sformatf("vec%0d", idx);
    runMove(v.c, v.win, gw, gr, gc, gs, grow, gcol, gp);
    checkOutput({tag, "_wr_en"}, 32'(gw), 32'(v.expWr));
    checkOutput({tag, "_reject"}, 32'(gr), 32'(v.expRej));
    if (v.expWr) begin
      checkOutput({tag, "_wr_row"}, 32'(grow), 32'(v.expRow));
      checkOutput({tag, "_wr_col"}, 32'(gcol), 32'(v.c));
      checkOutput({tag, "_wr_player"}, 32'(gp), 32'(v.expWrp));
      checkOutput({tag, "_chk_start"}, 32'(gc), 1);
    end
    checkOutput({tag, "_player"}, 32'(playerOut), 32'(v.expPlayer));
    checkOutput({tag, "_game_over"}, 32'(gameOver), 32'(v.expOver));
    checkOutput({tag, "_winner"}, 32'(winnerOut), 32'(v.expWinner));
  endtask

  task automatic modelMove(input logic [2:0] c, input logic win);
    logic gw, gr, gc, gs, gp;
    logic [2:0] grow, gcol;
    int legal;
    legal = (mOver == 0) && (c < 7) && (mHeight[c] < 6);
    runMove(c, win, gw, gr, gc, gs, grow, gcol, gp);
    if (mOver != 0) begin
      checkOutput("over_no_wr", 32'(gw), 0);
      checkOutput("over_no_reject", 32'(gr), 0);
    end else if (legal == 0) begin
      checkOutput("illegal_reject", 32'(gr), 1);
      checkOutput("illegal_no_wr", 32'(gw), 0);
    end else begin
      checkOutput("legal_wr_en", 32'(gw), 1);
      checkOutput("legal_wr_row", 32'(grow), 32'(mHeight[c]));
      checkOutput("legal_wr_col", 32'(gcol), 32'(c));
      checkOutput("legal_wr_player", 32'(gp), 32'(mTurn));
      checkOutput("legal_chk_start", 32'(gc), 1);
      checkOutput("legal_no_stray", 32'(gs), 0);
      mHeight[c]++;
      mMoves++;
      if (win) begin
        mOver = 1; mWinner = mTurn + 1;
      end else if (mMoves == 42) begin
        mOver = 1; mWinner = 3;
      end else begin
        mTurn = 1 - mTurn;
      end
    end
    checkOutput("model_player", 32'(playerOut), 32'(mTurn));
    checkOutput("model_game_over", 32'(gameOver), 32'(mOver));
    checkOutput("model_winner", 32'(winnerOut), 32'(mWinner));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failures++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, failures);
    $finish;
  end

  initial begin
    logic gw, gr, gc, gs, gp;
    logic [2:0] grow, gcol, c;
    int found;

    reset = 1'b1; newGamePulse = 1'b0; confirmPulse = 1'b0; colSel = '0;
    chkDone = 1'b0; chkWin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_player", 32'(playerOut), 0);
    checkOutput("rst_wr_en", 32'(wrEn), 0);
    checkOutput("rst_wr_row", 32'(wrRow), 0);
    checkOutput("rst_wr_col", 32'(wrCol), 0);
    checkOutput("rst_wr_player", 32'(wrPlayer), 0);
    checkOutput("rst_chk_start", 32'(chkStart), 0);
    checkOutput("rst_clear_board", 32'(clearBoard), 0);
    checkOutput("rst_reject", 32'(rejectPulse), 0);
    checkOutput("rst_game_over", 32'(gameOver), 0);
    checkOutput("rst_winner", 32'(winnerOut), 0);
    checkOutput("rst_timeout", 32'(timeoutPulse), 0);
    modelReset();

`ifdef TURN_TIMER_EN
    startNewGame();
    found = 0;
    for (int k = 2; k <= 15; k++) begin
      @(negedge clk);
      if (timeoutPulse && found == 0) found = k;
    end
    checkOutput("timer_expiry_cycle", 32'(found), 10);
    checkOutput("timer_player_toggled", 32'(playerOut), 1);
    repeat (5) @(negedge clk);
    confirmPulse = 1'b1; colSel = 3'd2;
    #1;
    checkOutput("timer_suppressed", 32'(timeoutPulse), 0);
    @(negedge clk); confirmPulse = 1'b0;
    checkOutput("timer_confirm_wr_en", 32'(wrEn), 1);
    checkOutput("timer_confirm_wr_player", 32'(wrPlayer), 1);
    @(negedge clk);
    chkDone = 1'b1;
    @(negedge clk); chkDone = 1'b0;
    checkOutput("timer_after_move_player", 32'(playerOut), 0);
`else
    vecs[0]  = '{3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{3'd7, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{3'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[11] = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd1};
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // new_game while the win check is pending
    startNewGame();
    @(negedge clk); confirmPulse = 1'b1; colSel = 3'd3;
    @(negedge clk); confirmPulse = 1'b0;
    @(negedge clk); newGamePulse = 1'b1;
    @(negedge clk); newGamePulse = 1'b0;
    checkOutput("ng_check_clear_board", 32'(clearBoard), 1);
    checkOutput("ng_check_player", 32'(playerOut), 0);
    modelReset();
    runMove(3'd3, 1'b0, gw, gr, gc, gs, grow, gcol, gp);
    checkOutput("ng_check_wr_en", 32'(gw), 1);
    checkOutput("ng_check_row", 32'(grow), 0);

    // new_game during DROP abandons the write
    startNewGame();
    @(negedge clk); confirmPulse = 1'b1; colSel = 3'd5;
    @(negedge clk); confirmPulse = 1'b0; newGamePulse = 1'b1;
    #1;
    checkOutput("ng_drop_no_wr", 32'(wrEn), 0);
    @(negedge clk); newGamePulse = 1'b0;
    checkOutput("ng_drop_clear_board", 32'(clearBoard), 1);
    @(negedge clk);
    checkOutput("ng_drop_no_chk_start", 32'(chkStart), 0);
    modelReset();
    modelMove(3'd5, 1'b0);

    // reset mid-move behaves like new_game without clear_board
    @(negedge clk); confirmPulse = 1'b1; colSel = 3'd4;
    @(negedge clk); confirmPulse = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkOutput("rst_mid_clear_board", 32'(clearBoard), 0);
    checkOutput("rst_mid_player", 32'(playerOut), 0);
    modelReset();
    modelMove(3'd4, 1'b0);
    modelMove(3'd5, 1'b0);

    // full board with no winner is a draw
    startNewGame();
    for (int cc = 0; cc < 7; cc++)
      for (int r = 0; r < 6; r++) modelMove(3'(cc), 1'b0);
    checkOutput("draw_winner", 32'(winnerOut), 3);
    checkOutput("draw_game_over", 32'(gameOver), 1);

    // randomized games
    for (int g = 0; g < 6; g++) begin
      startNewGame();
      for (int m = 0; m < 60 && mOver == 0; m++) begin
        c = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        modelMove(c, 1'($urandom_range(0, 29) == 0));
      end
      modelMove(3'($urandom_range(0, 6)), 1'b0);
    end

    checkOutput("timeout_tied_low", 32'(sawTimeout), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, failures);
    $finish;
  end

endmodule
